// File: rtl/ddr_capture_bank_if.sv
// Output side of the DDR capture bank: pair words leaving the FIFO.
// Ports: out_data {fall,rise} word, out_valid FIFO not empty, out_ready consumer accept,
//        count FIFO occupancy. master = capture bank, slave = consumer.
interface ddr_capture_bank_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
);
  logic [2*WIDTH-1:0]     out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] count;

  modport master (output out_data, output out_valid, output count, input out_ready);
  modport slave  (input out_data, input out_valid, input count, output out_ready);
endinterface

// File: rtl/ddr_capture_bank.sv
// Dual-edge input capture: per-lane follower q plus rise/fall pair packing into a FIFO.
// Latency: q one edge after sampling; a pair is visible one posedge after its rise sample.
// Backpressure: valid/ready pop; pushes into a full FIFO are dropped and flag sticky overflow.
// Ports: clk/reset (sync, active-high, sampled on both edges), mode_i q select, en_i pair
//        enable, d_i data, q_o follower, clr_ovf_i / overflow_o, out_if (master) pair output.
module ddr_capture_bank #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  input  logic             clr_ovf_i,
  output logic             overflow_o,
  ddr_capture_bank_if.master out_if
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // ---------------------------------------------------------------
  // Follower: q = p ^ n. Each edge rewrites only its own register so
  // that the XOR equals d at that edge; only one input of the XOR
  // changes per edge, so q never passes through an intermediate value.
  // mode 0/1 update at posedge, mode 0/2 at negedge, mode 3 holds.
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] p_q, n_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= '0;
    end else if (!mode_i[1]) begin
      p_q <= d_i ^ n_q;
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      n_q <= '0;
    end else if (!mode_i[0]) begin
      n_q <= d_i ^ p_q;
    end
  end

  assign q_o = p_q ^ n_q;

  // ---------------------------------------------------------------
  // Pair capture: rise sample at posedge t (when enabled), fall sample
  // at the following negedge, pushed together at posedge t+1.
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] rise_q, fall_q;
  logic             pend_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= '0;
      pend_q <= 1'b0;
    end else begin
      pend_q <= en_i;
      if (en_i) begin
        rise_q <= d_i;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      fall_q <= '0;
    end else begin
      fall_q <= d_i;
    end
  end

  // ---------------------------------------------------------------
  // Pair FIFO: registered array, head word shown directly (fall-through
  // from storage, no bypass of the incoming pair).
  // ---------------------------------------------------------------
  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               full, pop, wr_en, drop;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    pop     = (count_q != '0) && out_if.out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    wr_en   = pend_q && (!full || pop);
    drop    = pend_q && full && !pop;
    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CW'(1);
    end
    // A drop on the clearing edge wins so no loss goes unreported.
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {fall_q, rise_q};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_if.out_data  = mem_q[rd_ptr_q];
  assign out_if.out_valid = (count_q != '0);
  assign out_if.count     = count_q;
  assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_ddr_capture_bank.sv
// Bench for ddr_capture_bank: directed scenarios with literal expectations, then a
// randomized run, all compared on every clock edge against a queue-based reference model.
module tb_ddr_capture_bank;
  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   mode;
  logic         en;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         clr_ovf;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  ddr_capture_bank_if #(.WIDTH(W), .DEPTH(D)) bus ();

  ddr_capture_bank #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_i    (mode),
    .en_i      (en),
    .d_i       (d),
    .q_o       (q),
    .clr_ovf_i (clr_ovf),
    .overflow_o(overflow),
    .out_if    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // q is d at the most recent edge admitted by mode; pairs live in a queue.
  logic [2*W-1:0] mq[$];
  logic [W-1:0]   q_m    = '0;
  logic [W-1:0]   rise_m = '0;
  logic [W-1:0]   fall_m = '0;
  logic           pend_m = 1'b0;
  logic           ovf_m  = 1'b0;
  logic           prev_rst = 1'b0;

  initial begin
    bit pos, rs, skip_q, popd, drop;
    forever begin
      @(clk);
      if ($time == 0) continue;
      pos    = (clk === 1'b1);
      rs     = (reset === 1'b1);
      skip_q = 1'b0;
      if (rs) begin
        // q is only defined once both edge registers have seen reset.
        if (prev_rst) q_m = '0;
        else skip_q = 1'b1;
        if (pos) begin
          mq.delete();
          pend_m = 1'b0;
          ovf_m  = 1'b0;
        end
      end else if (pos) begin
        if (mode == 2'd0 || mode == 2'd1) q_m = d;
        popd = (mq.size() > 0) && (bus.out_ready === 1'b1);
        if (popd) void'(mq.pop_front());
        drop = 1'b0;
        if (pend_m) begin
          if (mq.size() < D) mq.push_back({fall_m, rise_m});
          else drop = 1'b1;
        end
        if (drop) ovf_m = 1'b1;
        else if (clr_ovf) ovf_m = 1'b0;
        pend_m = en;
        if (en) rise_m = d;
      end else begin
        if (mode == 2'd0 || mode == 2'd2) q_m = d;
        fall_m = d;
      end
      prev_rst = rs;
      #2;
      if (!skip_q) chk("model_q", q, q_m);
      chk("model_valid", bus.out_valid, (mq.size() > 0));
      chk("model_count", bus.count, mq.size());
      chk("model_overflow", overflow, ovf_m);
      if (mq.size() > 0) chk("model_data", bus.out_data, mq[0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
    #1;
  endtask

  logic [W-1:0] r0, f0, r1, f1, rv, fv;

  initial begin
    reset = 1'b1; mode = 2'd0; en = 1'b0; d = '0; bus.out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) to_pos();
    chk("rst_count", bus.count, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_q", q, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;

    // mode 0: q follows every edge
    d = 4'h0;
    repeat (4) begin
      to_neg(); chk("m0_fall_q", q, 4'h0); d = 4'hF;
      to_pos(); chk("m0_rise_q", q, 4'hF); d = 4'h0;
    end

    // mode 1: rise samples only
    mode = 2'd1;
    repeat (3) begin
      to_neg(); chk("m1_q", q, 4'hF); d = 4'hF;
      to_pos(); chk("m1_q", q, 4'hF); d = 4'h0;
    end

    // mode 2: fall samples only
    mode = 2'd2;
    repeat (3) begin
      to_neg(); chk("m2_q", q, 4'h0); d = 4'hF;
      to_pos(); chk("m2_q", q, 4'h0); d = 4'h0;
    end

    // mode 3: frozen regardless of d
    mode = 2'd3;
    d = 4'h9;
    repeat (3) begin
      to_neg(); chk("m3_q", q, 4'h0); d = 4'($urandom_range(1, 15));
      to_pos(); chk("m3_q", q, 4'h0); d = 4'($urandom_range(1, 15));
    end

    // single pair A/5
    mode = 2'd0;
    to_neg(); d = 4'hA; en = 1'b1;
    to_pos(); en = 1'b0; d = 4'h5;
    to_neg(); d = 4'($urandom);
    to_pos();
    chk("pair_valid", bus.out_valid, 1);
    chk("pair_data", bus.out_data, 8'h5A);
    chk("pair_count", bus.count, 1);
    bus.out_ready = 1'b1;
    to_pos(); bus.out_ready = 1'b0;
    chk("pair_drained", bus.count, 0);

    // overfill: 6 pairs into 4 entries
    to_neg(); en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rv = 4'($urandom); d = rv;
      to_pos();
      fv = 4'($urandom); d = fv;
      to_neg();
      if (i == 0) begin r0 = rv; f0 = fv; end
      if (i == 1) begin r1 = rv; f1 = fv; end
    end
    en = 1'b0;
    to_pos();
    chk("full_count", bus.count, 4);
    chk("full_ovf", overflow, 1);
    chk("full_head", bus.out_data, {24'h0, f0, r0});

    // push and pop on the same edge while full
    en = 1'b1;
    to_neg(); to_pos(); en = 1'b0; bus.out_ready = 1'b1;
    to_neg(); to_pos(); bus.out_ready = 1'b0;
    chk("pp_count", bus.count, 4);
    chk("pp_ovf", overflow, 1);
    chk("pp_head", bus.out_data, {24'h0, f1, r1});
    clr_ovf = 1'b1;
    to_pos(); clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 0);

    // reset with count=3 and a pair pending
    bus.out_ready = 1'b1;
    to_pos(); bus.out_ready = 1'b0; en = 1'b1;
    to_pos();
    chk("pre_rst_count", bus.count, 3);
    reset = 1'b1; en = 1'b0;
    to_neg(); to_pos(); reset = 1'b0;
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    repeat (3) to_pos();
    chk("post_rst_count", bus.count, 0);
    chk("post_rst_valid", bus.out_valid, 0);

    // randomized run
    repeat (3000) begin
      mode          = 2'($urandom_range(0, 3));
      d             = 4'($urandom);
      en            = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) == 0);
      clr_ovf       = ($urandom_range(0, 15) == 0);
      reset         = ($urandom_range(0, 199) == 0);
      to_neg();
      d = 4'($urandom);
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
      to_pos();
    end
    reset = 1'b0;
    to_pos();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
